// File: rtl/module_spi_master_shift_engine.sv
// Full-duplex SPI master shift engine: one DATA_WIDTH word out on mosi_o and one in from miso_i
// per transfer, all four SPI modes, MSB- or LSB-first, sclk_o divided down from clk_i.
module module_spi_master_shift_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsb_first_i,
  input  logic                  tx_valid_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic                  cs_n_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_lsb;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_cs_n;
  logic                  r_rx_valid;
  logic [CW-1:0]         r_half;
  logic [EW-1:0]         r_edge;

  logic [EW-1:0]         w_edge_n;
  logic                  w_half_end;
  logic                  w_leading;
  logic                  w_sample;
  logic                  w_shift;

  // w_edge_n is the number of the sclk edge produced when the current half-period ends
  assign w_edge_n   = r_edge + EW'(1);
  assign w_half_end = (r_half == HALF_LAST);
  assign w_leading  = w_edge_n[0];
  assign w_sample   = r_cpha ? ~w_leading : w_leading;
  assign w_shift    = r_cpha ? (w_leading && (w_edge_n != EW'(1)))
                             : (!w_leading && (w_edge_n != EDGE_LAST));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_cs_n     <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_half     <= '0;
      r_edge     <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cs_n <= 1'b1;
          r_mosi <= 1'b0;
          r_sclk <= cpol_i;
          r_half <= '0;
          r_edge <= '0;
          if (tx_valid_i) begin
            r_tx    <= tx_data_i;
            r_cpol  <= cpol_i;
            r_cpha  <= cpha_i;
            r_lsb   <= lsb_first_i;
            r_mosi  <= lsb_first_i ? tx_data_i[0] : tx_data_i[DATA_WIDTH-1];
            r_cs_n  <= 1'b0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (w_half_end) begin
            r_half  <= '0;
            r_state <= XFER;
          end else begin
            r_half <= r_half + CW'(1);
          end
        end
        XFER: begin
          if (w_half_end) begin
            r_half <= '0;
            r_sclk <= ~r_sclk;
            r_edge <= w_edge_n;
            // Received bits land at the end opposite to where they leave, preserving TX order
            if (w_sample) begin
              if (r_lsb) r_rx <= {miso_i, r_rx[DATA_WIDTH-1:1]};
              else       r_rx <= {r_rx[DATA_WIDTH-2:0], miso_i};
            end
            if (w_shift) begin
              if (r_lsb) begin
                r_tx   <= {1'b0, r_tx[DATA_WIDTH-1:1]};
                r_mosi <= r_tx[1];
              end else begin
                r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                r_mosi <= r_tx[DATA_WIDTH-2];
              end
            end
            if (w_edge_n == EDGE_LAST) r_state <= HOLD;
          end else begin
            r_half <= r_half + CW'(1);
          end
        end
        HOLD: begin
          if (w_half_end) begin
            r_half  <= '0;
            r_cs_n  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_half <= r_half + CW'(1);
          end
        end
        DONE: begin
          r_rx_valid <= 1'b1;
          r_rx_data  <= r_rx;
          r_mosi     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_ready_o = (r_state == IDLE);
  assign busy_o     = (r_state != IDLE);
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign sclk_o     = r_sclk;
  assign mosi_o     = r_mosi;
  assign cs_n_o     = r_cs_n;

endmodule
